// File: rtl/alu_sequencer.sv
// Two-beat operand sequencer around a 16-bit ALU.
// Operand A arrives on the first accepted beat and B plus the opcode on the second.
// One cycle later the ALU result is registered and offered downstream.
// Only one operation is in flight at a time.

// Combinational 16-bit ALU: add, subtract, AND, NOT-B, plus a zero flag.
module ALU (
    input  logic [15:0] Ain,
    input  logic [15:0] Bin,
    input  logic [1:0]  ALUop,
    output logic [15:0] out,
    output logic        Z
);

    // Select the operation and flag an all-zero result.
    always_comb begin
        out = 16'h0000;
        case (ALUop)
            2'b00:   out = Ain + Bin;
            2'b01:   out = Ain - Bin;
            2'b10:   out = Ain & Bin;
            2'b11:   out = ~Bin;
            default: out = 16'h0000;
        endcase
        Z = (out == 16'h0000);
    end

endmodule

// state  | meaning
// WAIT_A | idle, accepting operand A
// WAIT_B | A held, accepting operand B and opcode
// EXEC   | one cycle, ALU result registered into out_c/out_z
// RESULT | out_valid high, waiting for out_ready
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_c,
    output logic        out_z,
    output logic        busy,
    output logic [7:0]  op_count
);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        EXEC   = 2'b10,
        RESULT = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] out_c_q, out_c_d;
    logic        out_z_q, out_z_d;
    logic [7:0]  op_count_q, op_count_d;

    logic [15:0] alu_out;
    logic        alu_z;
    logic        in_xfer;
    logic        out_xfer;

    ALU u_alu (
        .Ain   (a_q),
        .Bin   (b_q),
        .ALUop (op_q),
        .out   (alu_out),
        .Z     (alu_z)
    );

    // Handshake outputs depend on state only; reset forces them idle so nothing
    // appears acceptable or pending on an edge that reset will override anyway.
    always_comb begin
        in_ready  = ~reset & ((state_q == WAIT_A) | (state_q == WAIT_B));
        out_valid = ~reset & (state_q == RESULT);
        busy      = ~reset & (state_q != WAIT_A);
        in_xfer   = in_valid & in_ready;
        out_xfer  = out_valid & out_ready;
        out_c     = out_c_q;
        out_z     = out_z_q;
        op_count  = op_count_q;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        out_c_d    = out_c_q;
        out_z_d    = out_z_q;
        op_count_d = op_count_q;
        case (state_q)
            WAIT_A: begin
                if (in_xfer) begin
                    a_d     = in_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (in_xfer) begin
                    b_d     = in_data;
                    op_d    = in_op;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_c_d = alu_out;
                out_z_d = alu_z;
                state_d = RESULT;
            end
            RESULT: begin
                if (out_xfer) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_A;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            op_q       <= 2'b00;
            out_c_q    <= 16'h0000;
            out_z_q    <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            out_c_q    <= out_c_d;
            out_z_q    <= out_z_d;
            op_count_q <= op_count_d;
        end
    end

endmodule
